// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state type and constants for the pipeline controller
package pipe_pkg;

    localparam int REG_ADR_W = 3;
    localparam int DRAIN_CNT_W = 2;
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_CYCLES = 2'd2;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    // True when a register read in ID is live and matches the EX destination
    function automatic logic reg_match(
        input logic                 use_reg,
        input logic [REG_ADR_W-1:0] src_adr,
        input logic [REG_ADR_W-1:0] dst_adr
    );
        return use_reg && (src_adr == dst_adr);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between ID sources and EX load
module load_use_detect
    import pipe_pkg::*;
(
    input  logic                 from_main_mem_ex,
    input  logic [REG_ADR_W-1:0] regwrite_adr_ex,
    input  logic [REG_ADR_W-1:0] rs_id,
    input  logic [REG_ADR_W-1:0] rt_id,
    input  logic                 use_rs_id,
    input  logic                 use_rt_id,
    output logic                 hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = reg_match(use_rs_id, rs_id, regwrite_adr_ex);
    assign rt_hit = reg_match(use_rt_id, rt_id, regwrite_adr_ex);
    assign hazard = from_main_mem_ex && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush/halt controller; PIPE_CTRL_STATS_EN adds a stall cycle counter
module pipeline_ctrl
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADR_W-1:0]   rs_id,
    input  logic [REG_ADR_W-1:0]   rt_id,
    input  logic                   use_rs_id,
    input  logic                   use_rt_id,
    input  logic [REG_ADR_W-1:0]   regwrite_adr_ex,
    input  logic                   from_main_mem_ex,
    input  logic                   branch_taken_ex,
    input  logic                   is_halt_ex,
    input  logic                   mem_busy,
    input  logic                   restart,
    output logic                   pc_en,
    output logic                   en_ifid,
    output logic                   flush_ifid,
    output logic                   en_idex,
    output logic                   flush_idex,
    output logic                   en_exmem,
    output logic                   en_memwb,
    output logic                   halted
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    pipe_state_t            state_q;
    pipe_state_t            state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q;
    logic [DRAIN_CNT_W-1:0] drain_cnt_d;
    logic                   lu_stall_q;
    logic                   lu_stall_d;
    logic                   lu_hazard;

    load_use_detect u_load_use_detect (
        .from_main_mem_ex (from_main_mem_ex),
        .regwrite_adr_ex  (regwrite_adr_ex),
        .rs_id            (rs_id),
        .rt_id            (rt_id),
        .use_rs_id        (use_rs_id),
        .use_rt_id        (use_rt_id),
        .hazard           (lu_hazard)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            lu_stall_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            lu_stall_q  <= lu_stall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        lu_stall_d  = lu_stall_q;
        pc_en       = 1'b0;
        en_ifid     = 1'b0;
        flush_ifid  = 1'b0;
        en_idex     = 1'b0;
        flush_idex  = 1'b0;
        en_exmem    = 1'b0;
        en_memwb    = 1'b0;
        halted      = 1'b0;

        if (reset) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        // Full freeze; the one-shot load-use flag is kept as is
                    end else if (is_halt_ex) begin
                        en_idex     = 1'b1;
                        flush_idex  = 1'b1;
                        en_exmem    = 1'b1;
                        en_memwb    = 1'b1;
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_CYCLES;
                        lu_stall_d  = 1'b0;
                    end else if (branch_taken_ex) begin
                        pc_en      = 1'b1;
                        en_ifid    = 1'b1;
                        en_idex    = 1'b1;
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        lu_stall_d = 1'b0;
                    end else if (lu_hazard && !lu_stall_q) begin
                        // One bubble; the flag stops the same load stalling twice
                        en_idex    = 1'b1;
                        flush_idex = 1'b1;
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                        lu_stall_d = 1'b1;
                    end else begin
                        pc_en      = 1'b1;
                        en_ifid    = 1'b1;
                        en_idex    = 1'b1;
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                        lu_stall_d = 1'b0;
                    end
                end

                DRAIN: begin
                    flush_idex = 1'b1;
                    en_idex    = !mem_busy;
                    en_exmem   = !mem_busy;
                    en_memwb   = !mem_busy;
                    if (!mem_busy && drain_cnt_q != '0) begin
                        drain_cnt_d = drain_cnt_q - 1'b1;
                        if (drain_cnt_q == 2'd1) begin
                            state_d = HALTED;
                        end
                    end
                end

                HALTED: begin
                    halted = 1'b1;
                    if (restart) begin
                        pc_en      = 1'b1;
                        en_ifid    = 1'b1;
                        en_idex    = 1'b1;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        state_d    = RUN;
                        lu_stall_d = 1'b0;
                    end
                end

                default: begin
                    state_d     = RUN;
                    drain_cnt_d = '0;
                    lu_stall_d  = 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (state_q == RUN && !pc_en && stall_cycles != {STALL_CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule
